// File: rtl/ca_pkg.sv
// ca_pkg: shared types and constants for the cellular-automaton sequencer.
//   seed_mode_t : how the line generator builds its first line
//   state_t     : sequencer FSM states
//   entry_t     : one playlist entry {rule, seed_mode}
//   PLAYLIST    : fixed 8-entry rule playlist
//   LFSR_TAPS   : Galois mask for x^16+x^14+x^13+x^11
package ca_pkg;

    localparam int unsigned RULE_W       = 8;
    localparam int unsigned IDX_W        = 3;
    localparam int unsigned LFSR_W       = 16;
    localparam int unsigned DWELL_W      = 16;
    localparam int unsigned PLAYLIST_LEN = 8;

    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        SEED_CENTER = 2'd0,
        SEED_EDGE   = 2'd1,
        SEED_RANDOM = 2'd2
    } seed_mode_t;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [RULE_W-1:0] rule;
        seed_mode_t        mode;
    } entry_t;

    localparam entry_t PLAYLIST [PLAYLIST_LEN] = '{
        '{rule: 8'd30,  mode: SEED_CENTER},
        '{rule: 8'd90,  mode: SEED_CENTER},
        '{rule: 8'd110, mode: SEED_EDGE},
        '{rule: 8'd105, mode: SEED_CENTER},
        '{rule: 8'd150, mode: SEED_CENTER},
        '{rule: 8'd184, mode: SEED_RANDOM},
        '{rule: 8'd45,  mode: SEED_CENTER},
        '{rule: 8'd73,  mode: SEED_RANDOM}
    };

endpackage

// File: rtl/ca_lfsr16.sv
// ca_lfsr16: free-running 16-bit Galois LFSR used as the reseed source.
//   clk  : clock
//   rst  : synchronous active-high reset, loads init
//   init : reset value (must be nonzero)
//   q    : current LFSR state, advances every cycle
module ca_lfsr16
    import ca_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] init,
    output logic [LFSR_W-1:0] q
);

    // Right-shifting Galois form: the bit shifted out folds back through the tap mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= init;
        end else begin
            q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : LFSR_W'(0));
        end
    end

endmodule

// File: rtl/ca_sequencer.sv
// ca_sequencer: frame-level rule/seed controller for the CA line generator.
// Steps through a fixed playlist on a dwell timer, takes next/prev/reseed/hold
// requests, and applies every change only at frame_end so the image never tears.
//   clk, rst          : clock, synchronous active-high reset
//   frame_end         : one-cycle pulse on the last pixel of a frame
//   btn_next/prev     : step playlist index forward/backward
//   btn_reseed        : reload current rule with a random seed
//   btn_hold          : toggle auto-advance freeze
//   rule, seed_mode   : active rule and seed type for the generator
//   seed_word         : LFSR snapshot used when seed_mode is random
//   load_seed         : one-cycle pulse, generator reloads its first line
//   holding           : high while auto-advance is frozen
//   playlist_idx      : current playlist index
module ca_sequencer
    import ca_pkg::*;
#(
    parameter int unsigned       DWELL_FRAMES = 300,
    parameter logic [LFSR_W-1:0] LFSR_INIT    = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_end,
    input  logic               btn_next,
    input  logic               btn_prev,
    input  logic               btn_reseed,
    input  logic               btn_hold,
    output logic [RULE_W-1:0]  rule,
    output logic [1:0]         seed_mode,
    output logic [LFSR_W-1:0]  seed_word,
    output logic               load_seed,
    output logic               holding,
    output logic [IDX_W-1:0]   playlist_idx
);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_d;
    logic [RULE_W-1:0]  rule_d;
    seed_mode_t         mode_q, mode_d;
    logic [LFSR_W-1:0]  word_d;
    logic               load_d;
    logic               holding_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               pend_next_q, pend_prev_q, pend_reseed_q, pend_hold_q;
    logic               pend_next_d, pend_prev_d, pend_reseed_d, pend_hold_d;
    logic               eff_next, eff_prev, eff_reseed, eff_hold;
    logic               idx_chg;
    entry_t             ent;
    logic [LFSR_W-1:0]  lfsr_q;

    ca_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .init (LFSR_INIT),
        .q    (lfsr_q)
    );

    // A button pulse in the frame_end cycle itself is consumed at that frame_end.
    assign eff_next   = pend_next_q   | btn_next;
    assign eff_prev   = pend_prev_q   | btn_prev;
    assign eff_reseed = pend_reseed_q | btn_reseed;
    assign eff_hold   = pend_hold_q   | btn_hold;

    assign seed_mode = mode_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and frame-boundary update logic.
    always_comb begin
        state_d       = state_q;
        idx_d         = playlist_idx;
        rule_d        = rule;
        mode_d        = mode_q;
        word_d        = seed_word;
        load_d        = 1'b0;
        dwell_d       = dwell_q;
        pend_next_d   = eff_next;
        pend_prev_d   = eff_prev;
        pend_reseed_d = eff_reseed;
        pend_hold_d   = eff_hold;
        idx_chg       = 1'b0;
        ent           = PLAYLIST[playlist_idx];

        if (frame_end) begin
            unique case (state_q)
                // First frame after reset: start at entry 0; pending requests stay latched.
                INIT: begin
                    state_d = RUN;
                    idx_d   = '0;
                    ent     = PLAYLIST[0];
                    rule_d  = ent.rule;
                    mode_d  = ent.mode;
                    if (ent.mode == SEED_RANDOM) begin
                        word_d = lfsr_q;
                    end
                    dwell_d = '0;
                    load_d  = 1'b1;
                end
                RUN, HOLD: begin
                    if (eff_hold) begin
                        state_d = (state_q == RUN) ? HOLD : RUN;
                    end
                    // Manual index change; next and prev together cancel.
                    if (eff_next && !eff_prev) begin
                        idx_d   = playlist_idx + IDX_W'(1);
                        idx_chg = 1'b1;
                    end else if (eff_prev && !eff_next) begin
                        idx_d   = playlist_idx - IDX_W'(1);
                        idx_chg = 1'b1;
                    end else if (state_d == RUN) begin
                        if (dwell_q == DWELL_LAST) begin
                            idx_d   = playlist_idx + IDX_W'(1);
                            idx_chg = 1'b1;
                        end else begin
                            dwell_d = dwell_q + DWELL_W'(1);
                        end
                    end
                    if (idx_chg) begin
                        ent     = PLAYLIST[idx_d];
                        rule_d  = ent.rule;
                        mode_d  = ent.mode;
                        if (ent.mode == SEED_RANDOM) begin
                            word_d = lfsr_q;
                        end
                        dwell_d = '0;
                        load_d  = 1'b1;
                    end
                    // Reseed overrides the entry's seed mode, even on an index change.
                    if (eff_reseed) begin
                        mode_d  = SEED_RANDOM;
                        word_d  = lfsr_q;
                        dwell_d = '0;
                        load_d  = 1'b1;
                    end
                    pend_next_d   = 1'b0;
                    pend_prev_d   = 1'b0;
                    pend_reseed_d = 1'b0;
                    pend_hold_d   = 1'b0;
                end
                default: begin
                    state_d = INIT;
                end
            endcase
        end

        holding_d = (state_d == HOLD);
    end

    // Output, dwell and pending-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            playlist_idx  <= '0;
            rule          <= PLAYLIST[0].rule;
            mode_q        <= SEED_CENTER;
            seed_word     <= LFSR_INIT;
            load_seed     <= 1'b0;
            holding       <= 1'b0;
            dwell_q       <= '0;
            pend_next_q   <= 1'b0;
            pend_prev_q   <= 1'b0;
            pend_reseed_q <= 1'b0;
            pend_hold_q   <= 1'b0;
        end else begin
            playlist_idx  <= idx_d;
            rule          <= rule_d;
            mode_q        <= mode_d;
            seed_word     <= word_d;
            load_seed     <= load_d;
            holding       <= holding_d;
            dwell_q       <= dwell_d;
            pend_next_q   <= pend_next_d;
            pend_prev_q   <= pend_prev_d;
            pend_reseed_q <= pend_reseed_d;
            pend_hold_q   <= pend_hold_d;
        end
    end

endmodule

// File: tb/tb_ca_sequencer.sv
// tb_ca_sequencer: scoreboard bench for ca_sequencer with a behavioural
// playlist/LFSR model; directed scenarios followed by randomized frames.
module tb_ca_sequencer;

    localparam int unsigned DW        = 3;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic [7:0]  rule;
        logic [1:0]  mode;
        logic [15:0] word;
        logic [2:0]  idx;
        logic        hold;
        logic        load;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst, frame_end, btn_next, btn_prev, btn_reseed, btn_hold;
    logic [7:0]  rule;
    logic [1:0]  seed_mode;
    logic [15:0] seed_word;
    logic        load_seed, holding;
    logic [2:0]  playlist_idx;

    int checks = 0;
    int errors = 0;

    ca_sequencer #(.DWELL_FRAMES(DW), .LFSR_INIT(LFSR_SEED)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_end    (frame_end),
        .btn_next     (btn_next),
        .btn_prev     (btn_prev),
        .btn_reseed   (btn_reseed),
        .btn_hold     (btn_hold),
        .rule         (rule),
        .seed_mode    (seed_mode),
        .seed_word    (seed_word),
        .load_seed    (load_seed),
        .holding      (holding),
        .playlist_idx (playlist_idx)
    );

    always #5 clk = ~clk;

    // Reference model state.
    int          pl_rule [8] = '{30, 90, 110, 105, 150, 184, 45, 73};
    int          pl_mode [8] = '{0, 0, 1, 0, 0, 2, 0, 2};
    obs_t        exp_q[$];
    logic [15:0] m_lfsr;
    bit          m_init, m_hold;
    int          m_idx, m_rule, m_mode, m_dwell;
    logic [15:0] m_word;
    bit          p_next, p_prev, p_reseed, p_hold;
    bit          ev = 1'b0;
    bit          mon_en = 1'b0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] r;
        r = {1'b0, s[15:1]};
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic obs_t snap(input bit ld);
        obs_t o;
        o.rule = 8'(m_rule);
        o.mode = 2'(m_mode);
        o.word = m_word;
        o.idx  = 3'(m_idx);
        o.hold = m_hold;
        o.load = ld;
        return o;
    endfunction

    // Model: evaluates the sequencer's rules at each clock edge and queues the
    // expected outputs for every reset or frame_end.
    initial begin
        forever begin
            @(posedge clk);
            ev     = rst | frame_end;
            mon_en = 1'b1;
            if (rst) begin
                m_init = 1'b1; m_hold = 1'b0; m_idx = 0; m_rule = 30; m_mode = 0;
                m_word = LFSR_SEED; m_dwell = 0;
                p_next = 0; p_prev = 0; p_reseed = 0; p_hold = 0;
                exp_q.push_back(snap(1'b0));
                m_lfsr = LFSR_SEED;
            end else begin
                bit n, p, rs, h, chg, ld;
                n  = p_next   | btn_next;
                p  = p_prev   | btn_prev;
                rs = p_reseed | btn_reseed;
                h  = p_hold   | btn_hold;
                p_next = n; p_prev = p; p_reseed = rs; p_hold = h;
                if (frame_end) begin
                    ld = 1'b1;
                    if (m_init) begin
                        m_init = 1'b0; m_idx = 0; m_rule = pl_rule[0]; m_mode = pl_mode[0];
                        m_dwell = 0;
                    end else begin
                        chg = 1'b0;
                        if (h) m_hold = !m_hold;
                        if (n && !p) begin
                            m_idx = (m_idx + 1) % 8; chg = 1'b1;
                        end else if (p && !n) begin
                            m_idx = (m_idx + 7) % 8; chg = 1'b1;
                        end else if (!m_hold) begin
                            m_dwell++;
                            if (m_dwell == DW) begin
                                m_idx = (m_idx + 1) % 8; chg = 1'b1;
                            end
                        end
                        if (chg) begin
                            m_rule = pl_rule[m_idx]; m_mode = pl_mode[m_idx]; m_dwell = 0;
                            if (m_mode == 2) m_word = m_lfsr;
                        end
                        if (rs) begin
                            m_mode = 2; m_word = m_lfsr; m_dwell = 0;
                        end
                        ld = chg | rs;
                        p_next = 0; p_prev = 0; p_reseed = 0; p_hold = 0;
                    end
                    exp_q.push_back(snap(ld));
                end
                m_lfsr = lfsr_step(m_lfsr);
            end
        end
    end

    // Monitor: after each reset/frame_end cycle pop and compare; otherwise
    // outputs must hold their last value with load_seed low.
    obs_t last;
    initial begin
        forever begin
            obs_t act, e;
            @(negedge clk);
            if (mon_en) begin
                act = '{rule: rule, mode: seed_mode, word: seed_word, idx: playlist_idx,
                        hold: holding, load: load_seed};
                checks++;
                if (ev) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_underflow t=%0t: no expected entry", $time);
                    end else begin
                        e = exp_q.pop_front();
                        last = e;
                        last.load = 1'b0;
                        if (act !== e) begin
                            errors++;
                            $display("FAIL update t=%0t got rule=%0d mode=%0d word=%h idx=%0d hold=%0d load=%0d exp rule=%0d mode=%0d word=%h idx=%0d hold=%0d load=%0d",
                                     $time, act.rule, act.mode, act.word, act.idx, act.hold, act.load,
                                     e.rule, e.mode, e.word, e.idx, e.hold, e.load);
                        end
                    end
                end else if (act !== last) begin
                    errors++;
                    $display("FAIL stable t=%0t got rule=%0d mode=%0d word=%h idx=%0d hold=%0d load=%0d exp rule=%0d mode=%0d word=%h idx=%0d hold=%0d load=0",
                             $time, act.rule, act.mode, act.word, act.idx, act.hold, act.load,
                             last.rule, last.mode, last.word, last.idx, last.hold);
                end
            end
        end
    end

    localparam logic [3:0] B_NONE = 4'b0000, B_NEXT = 4'b0001, B_PREV = 4'b0010,
                           B_RESEED = 4'b0100, B_HOLD = 4'b1000;

    // One frame of len cycles; frame_end on the last cycle, buttons at at1/at2,
    // optional reset at rst_at (-1 for none).
    task automatic run_frame(input int len, input int at1, input logic [3:0] b1,
                             input int at2, input logic [3:0] b2, input int rst_at);
        for (int c = 0; c < len; c++) begin
            logic [3:0] b;
            b = (c == at1 ? b1 : B_NONE) | (c == at2 ? b2 : B_NONE);
            frame_end = (c == len - 1);
            {btn_hold, btn_reseed, btn_prev, btn_next} = b;
            rst = (c == rst_at);
            @(posedge clk);
            #1;
        end
        frame_end = 1'b0; rst = 1'b0;
        {btn_hold, btn_reseed, btn_prev, btn_next} = B_NONE;
    endtask

    task automatic idle(input int len);
        run_frame(len, -1, B_NONE, -1, B_NONE, -1);
    endtask

    initial begin
        rst = 1'b1; frame_end = 1'b0;
        btn_next = 1'b0; btn_prev = 1'b0; btn_reseed = 1'b0; btn_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Start-up and first auto-advance.
        for (int i = 0; i < 4; i++) idle(5);
        // Walk to idx 7, then next wraps to 0.
        for (int i = 0; i < 6; i++) run_frame(5, 1, B_NEXT, -1, B_NONE, -1);
        run_frame(6, 2, B_NEXT, -1, B_NONE, -1);
        // next and prev cancel.
        run_frame(6, 1, B_NEXT, 3, B_PREV, -1);
        // Hold for two dwell periods, then navigate and prev in HOLD.
        run_frame(5, 4, B_HOLD, -1, B_NONE, -1);
        for (int i = 0; i < 2 * DW; i++) idle(4);
        for (int i = 0; i < 3; i++) run_frame(4, 0, B_NEXT, -1, B_NONE, -1);
        run_frame(4, 2, B_PREV, -1, B_NONE, -1);
        // Double reseed in one frame, then another reseed.
        run_frame(6, 1, B_RESEED, 3, B_RESEED, -1);
        run_frame(5, 4, B_RESEED, -1, B_NONE, -1);
        run_frame(5, 0, B_HOLD, -1, B_NONE, -1);
        // Reset mid-frame with a pending next.
        run_frame(6, 1, B_NEXT, -1, B_NONE, 3);
        idle(5);
        idle(5);

        // Randomized frames with sparse button pulses and occasional resets.
        for (int f = 0; f < 250; f++) begin
            int len, a1, a2, ra;
            logic [3:0] b1, b2;
            len = int'($urandom_range(2, 8));
            a1  = int'($urandom_range(0, len - 1));
            a2  = int'($urandom_range(0, len - 1));
            b1  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : B_NONE;
            b2  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : B_NONE;
            ra  = ($urandom_range(0, 30) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            run_frame(len, a1, b1, a2, b2, ra);
        end
        idle(4);
        repeat (2) @(posedge clk);
        #1;

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected updates never observed, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
